// File: rtl/pe_ctrl_pkg.sv
// Shared types and default sizes for the PE-array sequencer.
package pe_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   localparam int ARRAY_N_DEF = 8;
   localparam int LEN_W_DEF   = 8;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Job request, ifmap/psum flow control and array strobes of the sequencer.
interface pe_array_ctrl_if
   import pe_ctrl_pkg::*;
#(
   parameter int ARRAY_N = ARRAY_N_DEF,
   parameter int LEN_W   = LEN_W_DEF
) ();

   logic                       start;
   logic [LEN_W-1:0]           cfg_len;
   logic                       if_valid;
   logic                       out_ready;
   logic                       enable_w;
   logic [$clog2(ARRAY_N)-1:0] w_addr;
   logic                       w_rd;
   logic                       Run;
   logic                       if_rd;
   logic                       if_zero;
   logic                       out_valid;
   logic                       busy;
   logic                       done;

   // System side: issues jobs, owns the buffers and the psum sink.
   modport master (
      output start, cfg_len, if_valid, out_ready,
      input  enable_w, w_addr, w_rd, Run, if_rd, if_zero, out_valid, busy, done
   );

   // Sequencer side.
   modport slave (
      input  start, cfg_len, if_valid, out_ready,
      output enable_w, w_addr, w_rd, Run, if_rd, if_zero, out_valid, busy, done
   );

endinterface

// File: rtl/pe_step_counter.sv
// Enable/clear step counter that wraps to zero after reaching 'last' and
// flags the terminal count combinationally.
module pe_step_counter #(
   parameter int W = 3
) (
   input  logic         iClk,
   input  logic         iRest_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == last);

   // Clear wins over enable; wrapping at 'last' leaves the counter at zero
   // once its phase is over.
   always_ff @(posedge iClk) begin
      if (!iRest_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/pe_array_ctrl.sv
// Sequencer for the systolic PE chain: weight load, ifmap streaming with
// valid/ready flow control, zero-bubble drain and psum-valid flagging.
module pe_array_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int Data_width = 8,
   parameter int ARRAY_N    = ARRAY_N_DEF,
   parameter int LEN_W      = LEN_W_DEF
) (
   input logic            iClk,
   input logic            iRest_n,
   pe_array_ctrl_if.slave bus
);

   localparam int              CW      = $clog2(ARRAY_N);
   localparam logic [CW-1:0]   LAST_PE = CW'(ARRAY_N - 1);
   localparam logic [LEN_W:0]  OV_THR  = (LEN_W + 1)'(ARRAY_N);

   // A chain shorter than two PEs has no drain phase to speak of.
   if (ARRAY_N < 2 || Data_width < 1) begin : g_param_check
      $error("pe_array_ctrl: ARRAY_N must be >= 2 and Data_width >= 1");
   end

   state_t           state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W:0]   run_cnt;
   logic             busy_q;
   logic             load_q;
   logic             stream_q;
   logic             drain_q;
   logic             done_q;
   logic             accept;
   logic             run;
   logic [CW-1:0]    w_addr;
   logic [LEN_W-1:0] beat_cnt;
   logic [CW-1:0]    drain_cnt;
   logic             w_tc;
   logic             beat_tc;
   logic             drain_tc;
   logic             unused_cnt;

   assign accept = (state == IDLE) && bus.start;
   assign run    = (stream_q && bus.if_valid && bus.out_ready) ||
                   (drain_q && bus.out_ready);

   // Weight-buffer address, one PE per LOAD_W cycle.
   pe_step_counter #(.W(CW)) u_w_addr (
      .iClk    (iClk),
      .iRest_n (iRest_n),
      .clr     (accept),
      .en      (load_q),
      .last    (LAST_PE),
      .cnt     (w_addr),
      .tc      (w_tc)
   );

   // Ifmap beats consumed in STREAM.
   pe_step_counter #(.W(LEN_W)) u_beat_cnt (
      .iClk    (iClk),
      .iRest_n (iRest_n),
      .clr     (accept),
      .en      (run && stream_q),
      .last    (len_q - LEN_W'(1)),
      .cnt     (beat_cnt),
      .tc      (beat_tc)
   );

   // Zero bubbles pushed in DRAIN to flush the chain.
   pe_step_counter #(.W(CW)) u_drain_cnt (
      .iClk    (iClk),
      .iRest_n (iRest_n),
      .clr     (accept),
      .en      (run && drain_q),
      .last    (LAST_PE),
      .cnt     (drain_cnt),
      .tc      (drain_tc)
   );

   // Beat and drain counts matter only through their terminal-count flags.
   assign unused_cnt = ^{beat_cnt, drain_cnt};

   // Job FSM with the phase flags registered alongside the state.
   always_ff @(posedge iClk) begin
      if (!iRest_n) begin
         state    <= IDLE;
         len_q    <= '0;
         busy_q   <= 1'b0;
         load_q   <= 1'b0;
         stream_q <= 1'b0;
         drain_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  len_q  <= bus.cfg_len;
                  busy_q <= 1'b1;
                  load_q <= 1'b1;
                  state  <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (w_tc) begin
                  load_q <= 1'b0;
                  if (len_q != '0) begin
                     stream_q <= 1'b1;
                     state    <= STREAM;
                  end else begin
                     done_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            STREAM: begin
               if (run && beat_tc) begin
                  stream_q <= 1'b0;
                  drain_q  <= 1'b1;
                  state    <= DRAIN;
               end
            end
            DRAIN: begin
               if (run && drain_tc) begin
                  drain_q <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q   <= 1'b0;
               load_q   <= 1'b0;
               stream_q <= 1'b0;
               drain_q  <= 1'b0;
               done_q   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   // Run cycles of the whole job; one bit wider than cfg_len so the
   // longest job plus the drain never wraps.
   always_ff @(posedge iClk) begin
      if (!iRest_n) begin
         run_cnt <= '0;
      end else if (accept) begin
         run_cnt <= '0;
      end else if (run) begin
         run_cnt <= run_cnt + (LEN_W + 1)'(1);
      end
   end

   assign bus.enable_w  = load_q;
   assign bus.w_rd      = load_q;
   assign bus.w_addr    = w_addr;
   assign bus.Run       = run;
   assign bus.if_zero   = drain_q;
   assign bus.if_rd     = run && !drain_q;
   assign bus.out_valid = run && (run_cnt >= OV_THR);
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl: job-level reference model driven
// by randomized and scheduled flow-control stimulus.
module tb_pe_array_ctrl;

   localparam int N     = 8;
   localparam int LW    = 8;
   localparam int CW    = $clog2(N);
   localparam int OW    = 8 + CW;
   localparam int LIMIT = 4000;

   logic iClk    = 1'b0;
   logic iRest_n = 1'b0;

   always #5 iClk = ~iClk;

   pe_array_ctrl_if #(.ARRAY_N(N), .LEN_W(LW)) bus ();

   pe_array_ctrl #(.Data_width(8), .ARRAY_N(N), .LEN_W(LW)) dut (
      .iClk    (iClk),
      .iRest_n (iRest_n),
      .bus     (bus)
   );

   // {busy, done, enable_w, w_rd, w_addr, Run, if_rd, if_zero, out_valid}
   logic [OW-1:0] act;
   assign act = {bus.busy, bus.done, bus.enable_w, bus.w_rd, bus.w_addr,
                 bus.Run, bus.if_rd, bus.if_zero, bus.out_valid};

   int checks   = 0;
   int failures = 0;

   int            bad_cycles;
   int            first_bad_c;
   logic [OW-1:0] first_act;
   logic [OW-1:0] first_exp;
   int            obs_en, obs_runs, obs_ifrd, obs_ifz, obs_ov;
   int            obs_done_cnt, obs_done_c, obs_run_low;
   bit            timed_out;

   // One job against the model: load for N cycles, then (if L > 0) L+N Run
   // cycles where the first L consume beats and Run k flags a psum for k >= N,
   // then one done cycle, then idle. Ends after 3 idle cycles, or at the
   // sample of the cycle in which reset is asserted when abort_runs >= 0.
   task automatic run_job(input int L, input int iv_pct, input int or_pct,
                          input int iv_drop_at, input int iv_drop_len,
                          input int or_drop_at, input int or_drop_len,
                          input int start_again_c, input int abort_runs);
      int r = 0;
      int idle = 0;
      int done_c = 0;
      int iv_rem = 0;
      int or_rem = 0;
      bit iv_trig = 0;
      bit or_trig = 0;
      bit finished = 0;
      bit iv, orr, run_e, phase_run, abort;
      logic [OW-1:0] expv;
      bad_cycles = 0; first_bad_c = 0; first_act = '0; first_exp = '0;
      obs_en = 0; obs_runs = 0; obs_ifrd = 0; obs_ifz = 0; obs_ov = 0;
      obs_done_cnt = 0; obs_done_c = 0; obs_run_low = 0; timed_out = 0;
      @(posedge iClk); #1;
      bus.start     = 1'b1;
      bus.cfg_len   = LW'(L);
      bus.if_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge iClk); #1;
      bus.start = 1'b0;
      for (int c = 1; c <= LIMIT; c++) begin
         phase_run = (c > N) && (L > 0) && (r < L + N);
         iv  = ($urandom_range(0, 99) < iv_pct);
         orr = ($urandom_range(0, 99) < or_pct);
         if (iv_rem > 0) begin
            iv = 1'b0; iv_rem--;
         end else if (phase_run && !iv_trig && iv_drop_at >= 0 && r == iv_drop_at) begin
            iv_trig = 1'b1; iv = 1'b0; iv_rem = iv_drop_len - 1;
         end
         if (or_rem > 0) begin
            orr = 1'b0; or_rem--;
         end else if (phase_run && !or_trig && or_drop_at >= 0 && r == or_drop_at) begin
            or_trig = 1'b1; orr = 1'b0; or_rem = or_drop_len - 1;
         end
         bus.if_valid  = iv;
         bus.out_ready = orr;
         bus.cfg_len   = LW'($urandom);
         bus.start     = (c == start_again_c);
         abort = phase_run && (abort_runs >= 0) && (r == abort_runs);
         if (abort) iRest_n = 1'b0;

         expv = '0;
         if (c <= N) begin
            expv = {1'b1, 1'b0, 1'b1, 1'b1, CW'(c - 1), 4'b0000};
         end else if (phase_run) begin
            run_e = (r < L) ? (iv && orr) : orr;
            expv = {1'b1, 1'b0, 1'b0, 1'b0, CW'(0),
                    run_e, run_e && (r < L), (r >= L), run_e && (r >= N)};
            if (run_e) r++;
         end else if (done_c == 0) begin
            done_c = c;
            expv = {1'b1, 1'b1, 1'b0, 1'b0, CW'(0), 4'b0000};
         end else begin
            idle++;
         end

         @(negedge iClk);
         if (act !== expv) begin
            if (bad_cycles == 0) begin
               first_bad_c = c; first_act = act; first_exp = expv;
            end
            bad_cycles++;
         end
         obs_en   += int'(bus.enable_w);
         obs_runs += int'(bus.Run);
         obs_ifrd += int'(bus.if_rd);
         obs_ifz  += int'(bus.if_zero);
         obs_ov   += int'(bus.out_valid);
         if (phase_run && bus.Run !== 1'b1) obs_run_low++;
         if (bus.done === 1'b1) begin
            obs_done_cnt++;
            if (obs_done_c == 0) obs_done_c = c;
         end
         if (abort || idle == 3) begin
            finished = 1'b1;
            break;
         end
         @(posedge iClk); #1;
      end
      bus.start = 1'b0;
      if (!finished) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      iRest_n = 1'b0;
      bus.start = 1'b1; bus.cfg_len = 8'd5; bus.if_valid = 1'b1; bus.out_ready = 1'b1;
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      checks++;
      if (act !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got %h want %h", act, {OW{1'b0}});
      end
      #1 bus.start = 1'b0;
      @(posedge iClk); #1;
      iRest_n = 1'b1;
      @(posedge iClk);
      @(negedge iClk);
      checks++;
      if (act !== '0) begin
         failures++;
         $display("FAIL idle_after_reset: got %h want %h", act, {OW{1'b0}});
      end
   endtask

   task automatic test_basic();
      run_job(4, 100, 100, -1, 0, -1, 0, 0, -1);
      checks++;
      if (bad_cycles !== 0) begin
         failures++;
         $display("FAIL basic_trace: bad_cycles=%0d first cyc %0d got %h want %h",
                  bad_cycles, first_bad_c, first_act, first_exp);
      end
      checks++;
      if (obs_en !== N) begin
         failures++; $display("FAIL basic_enable_w: got %0d want %0d", obs_en, N);
      end
      checks++;
      if (obs_runs !== 12) begin
         failures++; $display("FAIL basic_runs: got %0d want 12", obs_runs);
      end
      checks++;
      if (obs_ifrd !== 4 || obs_ifz !== 8) begin
         failures++;
         $display("FAIL basic_if_rd_zero: got rd=%0d zero=%0d want rd=4 zero=8", obs_ifrd, obs_ifz);
      end
      checks++;
      if (obs_ov !== 4) begin
         failures++; $display("FAIL basic_out_valid: got %0d want 4", obs_ov);
      end
      checks++;
      if (obs_done_c !== 21 || obs_done_cnt !== 1) begin
         failures++;
         $display("FAIL basic_done: got cyc=%0d pulses=%0d want cyc=21 pulses=1", obs_done_c, obs_done_cnt);
      end
   endtask

   task automatic test_source_stall();
      run_job(3, 100, 100, 1, 5, -1, 0, 0, -1);
      checks++;
      if (bad_cycles !== 0) begin
         failures++;
         $display("FAIL src_stall_trace: bad_cycles=%0d first cyc %0d got %h want %h",
                  bad_cycles, first_bad_c, first_act, first_exp);
      end
      checks++;
      if (obs_run_low !== 5) begin
         failures++; $display("FAIL src_stall_run_low: got %0d want 5", obs_run_low);
      end
      checks++;
      if (obs_ifrd !== 3 || obs_ov !== 3) begin
         failures++;
         $display("FAIL src_stall_counts: got beats=%0d psums=%0d want 3/3", obs_ifrd, obs_ov);
      end
      checks++;
      if (obs_done_c !== 25) begin
         failures++; $display("FAIL src_stall_done: got %0d want 25", obs_done_c);
      end
   endtask

   task automatic test_sink_stall();
      run_job(8, 100, 100, -1, 0, 10, 3, 0, -1);
      checks++;
      if (bad_cycles !== 0) begin
         failures++;
         $display("FAIL sink_stall_trace: bad_cycles=%0d first cyc %0d got %h want %h",
                  bad_cycles, first_bad_c, first_act, first_exp);
      end
      checks++;
      if (obs_run_low !== 3) begin
         failures++; $display("FAIL sink_stall_run_low: got %0d want 3", obs_run_low);
      end
      checks++;
      if (obs_ov !== 8 || obs_runs !== 16) begin
         failures++;
         $display("FAIL sink_stall_counts: got psums=%0d runs=%0d want 8/16", obs_ov, obs_runs);
      end
      checks++;
      if (obs_done_c !== 28) begin
         failures++; $display("FAIL sink_stall_done: got %0d want 28", obs_done_c);
      end
   endtask

   task automatic test_zero_len();
      run_job(0, 100, 100, -1, 0, -1, 0, 5, -1);
      checks++;
      if (bad_cycles !== 0) begin
         failures++;
         $display("FAIL zero_len_trace: bad_cycles=%0d first cyc %0d got %h want %h",
                  bad_cycles, first_bad_c, first_act, first_exp);
      end
      checks++;
      if (obs_en !== N || obs_runs !== 0) begin
         failures++;
         $display("FAIL zero_len_counts: got en=%0d runs=%0d want %0d/0", obs_en, obs_runs, N);
      end
      checks++;
      if (obs_done_c !== 9 || obs_done_cnt !== 1) begin
         failures++;
         $display("FAIL zero_len_done: got cyc=%0d pulses=%0d want cyc=9 pulses=1", obs_done_c, obs_done_cnt);
      end
   endtask

   task automatic test_mid_reset();
      int nonzero = 0;
      run_job(6, 100, 100, -1, 0, -1, 0, 0, 2);
      @(posedge iClk); #1;
      bus.if_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge iClk);
      checks++;
      if (act !== '0 || obs_done_cnt !== 0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %h done_pulses=%0d want 0/0", act, obs_done_cnt);
      end
      @(posedge iClk); #1;
      iRest_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge iClk);
         if (act !== '0) nonzero++;
         @(posedge iClk); #1;
      end
      checks++;
      if (nonzero !== 0) begin
         failures++; $display("FAIL mid_reset_idle: got %0d active cycles want 0", nonzero);
      end
      run_job(1, 100, 100, -1, 0, -1, 0, 0, -1);
      checks++;
      if (bad_cycles !== 0 || obs_ov !== 1 || obs_done_c !== 18) begin
         failures++;
         $display("FAIL mid_reset_rerun: bad=%0d psums=%0d done_cyc=%0d want 0/1/18",
                  bad_cycles, obs_ov, obs_done_c);
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 6; j++) begin
         int L;
         L = $urandom_range(0, 40);
         run_job(L, $urandom_range(50, 100), $urandom_range(50, 100),
                 -1, 0, -1, 0, $urandom_range(1, N + 2), -1);
         checks++;
         if (bad_cycles !== 0 || timed_out) begin
            failures++;
            $display("FAIL random_trace len=%0d: bad_cycles=%0d timeout=%0d first cyc %0d got %h want %h",
                     L, bad_cycles, timed_out, first_bad_c, first_act, first_exp);
         end
         checks++;
         if (obs_ov !== L || obs_ifrd !== L || obs_done_cnt !== 1) begin
            failures++;
            $display("FAIL random_counts len=%0d: got psums=%0d beats=%0d done=%0d", L, obs_ov, obs_ifrd, obs_done_cnt);
         end
      end
   endtask

   task automatic test_max_len();
      run_job(255, 80, 80, -1, 0, -1, 0, 0, -1);
      checks++;
      if (bad_cycles !== 0 || timed_out) begin
         failures++;
         $display("FAIL max_len_trace: bad_cycles=%0d timeout=%0d first cyc %0d got %h want %h",
                  bad_cycles, timed_out, first_bad_c, first_act, first_exp);
      end
      checks++;
      if (obs_ov !== 255 || obs_runs !== 263) begin
         failures++;
         $display("FAIL max_len_counts: got psums=%0d runs=%0d want 255/263", obs_ov, obs_runs);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.cfg_len = '0; bus.if_valid = 1'b0; bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_source_stall();
      test_sink_stall();
      test_zero_len();
      test_mid_reset();
      test_random();
      test_max_len();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pe_array_ctrl.md
# pe_array_ctrl

Sequencer for the 8-PE systolic array. It runs one job per `start`:
- loads the stationary weights (`enable_w`),
- streams a configured number of ifmap beats under `Run` with valid/ready flow control,
- drains the pipeline with zero bubbles,
- flags which `Run` cycles carry a valid partial sum on `Psum_t_down`.

It sits between the weight/ifmap buffers and the PE array, and is the only driver of `enable_w` and `Run`.

## Interface
- `Data_width`, default 8: datapath width; passed through to the array, not used internally.
- `ARRAY_N`, default 8: number of PEs in the chain (pipeline depth); must be ≥ 2.
- `LEN_W`, default 8: width of the beat-count configuration.

Ports:
- `iClk`  in  1  clock; all logic on rising edge.
- `iRest_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  job request; sampled only in IDLE.
- `cfg_len`  in  `LEN_W`  ifmap beats in the job; latched on an accepted `start`.
- `if_valid`  in  1  ifmap source has a beat.
- `out_ready`  in  1  psum sink can accept.
- `enable_w`  out  1  weight-load strobe to all PEs.
- `w_addr`  out  `$clog2(ARRAY_N)`  weight buffer address, one per PE.
- `w_rd`  out  1  weight buffer read strobe.
- `Run`  out  1  array advance strobe.
- `if_rd`  out  1  ifmap pop; source beat consumed this cycle.
- `if_zero`  out  1  array-side ifmap mux selects 0 (drain bubble).
- `out_valid`  out  1  `Psum_t_down` valid this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
Handshakes:
- `if_rd = Run & ~if_zero`.
- The ifmap handshake completes on `if_valid & if_rd`.
- The psum handshake completes on `out_valid & out_ready`.

State machine:
- **IDLE**
  - All outputs 0.
  - `start=1`: latch `cfg_len` into `len_q`, clear counters, go to LOAD_W.
- **LOAD_W**
  - `enable_w = w_rd = 1`; `w_addr` counts 0 … `ARRAY_N-1`, one per cycle.
  - After `w_addr = ARRAY_N-1`: go to STREAM if `len_q ≠ 0`, else to DONE.
- **STREAM**
  - `Run = if_valid & out_ready`; `if_zero = 0`.
  - `beat_cnt` increments on each `Run`.
  - Run cycle with `beat_cnt = len_q-1`: go to DRAIN.
- **DRAIN**
  - `Run = out_ready`; `if_zero = 1`; `if_valid` is ignored.
  - `drain_cnt` increments on each `Run`.
  - Run cycle with `drain_cnt = ARRAY_N-1`: go to DONE.
- **DONE**
  - `done = 1` for exactly one cycle, then IDLE.

Psum validity:
- `run_cnt` (width `LEN_W+1`) counts every `Run` cycle of the job, pre-increment value.
- `out_valid = Run & (run_cnt ≥ ARRAY_N)`.
- Total `Run` cycles = `len_q + ARRAY_N`; total `out_valid` cycles = `len_q`.

Boundary conditions:
- `start` while busy is ignored; `cfg_len` changes after latching have no effect.
- `cfg_len = 0`: weights load, no `Run`, `done` follows.
- `cfg_len = 2^LEN_W-1`: `run_cnt` must not wrap, hence `LEN_W+1` bits.
- `if_valid` low or `out_ready` low in STREAM: `Run`, `if_rd` and all counters hold.
- `out_ready` low in DRAIN: `Run` and counters hold.
- `iRest_n = 0` at any point, including mid-job: next edge returns to IDLE, all counters 0, all outputs 0, no `done` pulse.

## Timing
- Reset value of every output: 0.
- `start` accepted at edge *t*:
  - `enable_w` is high for cycles *t+1* … *t+ARRAY_N*.
  - The first possible `Run` is at cycle *t+ARRAY_N+1*.
- The beat consumed on Run cycle *k* produces its psum on Run cycle *k+ARRAY_N*, counted in `Run` cycles, not clock cycles.
- Unstalled job: `done` is asserted at cycle *t + 2·ARRAY_N + len + 1*.
- All outputs are registered-state decodes. `Run`, `if_rd` and `out_valid` are combinational in `if_valid` and `out_ready`; there are no other input-to-output paths.

## Structure
- Package `pe_ctrl_pkg`:
  - state enum `{IDLE, LOAD_W, STREAM, DRAIN, DONE}`;
  - `ARRAY_N_DEF = 8`;
  - `LEN_W_DEF = 8`.
- One sub-module, `pe_step_counter`: enable/clear counter with terminal-count flag.
  - Instanced three times: `w_addr`, `beat_cnt`, `drain_cnt`.
  - `run_cnt` stays inline.

## Test plan
- **Reset:** assert `iRest_n = 0` for 2 cycles → all outputs 0, `busy = 0`.
- **Basic job:** `cfg_len = 4`, `if_valid = out_ready = 1` → `enable_w` for 8 cycles with `w_addr` 0…7, then 12 consecutive `Run`; `if_rd` on the first 4, `if_zero` on the last 8, `out_valid` on Run cycles 9–12; `done` one cycle later; 21 cycles from `start` to `done`.
- **Source stall:** `cfg_len = 3`, drop `if_valid` for 5 cycles after beat 1 → `Run` low for those 5 cycles; beat and psum counts are still exactly 3.
- **Sink stall:** `cfg_len = 8`, drop `out_ready` for 3 cycles during DRAIN → `Run` and `out_valid` low for 3 cycles; 8 `out_valid` cycles in total.
- **Zero length:** `cfg_len = 0` → 8 `enable_w` cycles, no `Run`, `done` 9 cycles after `start`; a second `start` pulsed while busy causes no extra job.
- **Mid-job reset:** assert `iRest_n = 0` in STREAM after 2 beats → next edge gives IDLE and outputs 0 with no `done`; a new `start` with `cfg_len = 1` then completes normally with 1 `out_valid`.
